// File: rtl/vrf_wb_unit_pkg.sv
// Shared vector-unit types and defaults for the VRF write-back path.
package vrf_wb_unit_pkg;

    localparam int VLEN_DEF       = 16384;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int OFF_WIDTH_DEF  = $clog2(VLEN_DEF / DATA_WIDTH_DEF);

    // One buffered result beat; 'last' carries the instruction's end marker.
    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0]   data;
        logic [DATA_WIDTH_DEF/8-1:0] be;
        logic [ADDR_WIDTH_DEF-1:0]   addr;
        logic [OFF_WIDTH_DEF-1:0]    off;
        logic                        last;
    } wb_beat_t;

    typedef enum logic {
        TRK_IDLE = 1'b0,
        TRK_OPEN = 1'b1
    } trk_state_e;

endpackage

// File: rtl/vrf_wb_unit_wb_fifo.sv
// Synchronous circular FIFO; exposes its storage and per-slot valid mask
// so the parent can run a hazard compare over every pending entry.
module wb_fifo
    import vrf_wb_unit_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_beat_t
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  entry_t               din_i,
    output entry_t               dout_o,
    output logic                 full_o,
    output logic                 empty_o,
    output entry_t [DEPTH-1:0]   entries_o,
    output logic   [DEPTH-1:0]   vld_o
);

    localparam int PW = $clog2(DEPTH);

    logic   [PW-1:0]    wptr_q, rptr_q;
    logic   [PW:0]      cnt_q;
    entry_t [DEPTH-1:0] mem_q;
    logic               push_ok, pop_ok;
    logic   [PW-1:0]    rel;

    assign full_o    = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & ~empty_o;
    assign dout_o    = mem_q[rptr_q];
    assign entries_o = mem_q;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is deliberately left out of reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

    // A slot is live when its distance from the read pointer is below occupancy.
    always_comb begin
        vld_o = '0;
        rel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel      = PW'(i) - rptr_q;
            vld_o[i] = ({1'b0, rel} < cnt_q);
        end
    end

endmodule

// File: rtl/vrf_wb_unit.sv
// VRF write-back unit: buffers result beats, drains them to the VRF,
// tracks instruction framing and answers register hazard queries.
module vrf_wb_unit
    import vrf_wb_unit_pkg::*;
#(
    parameter int VLEN       = VLEN_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int OFF_WIDTH  = $clog2(VLEN / DATA_WIDTH),
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH/8-1:0] in_be,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [OFF_WIDTH-1:0]    in_off,
    input  logic                    in_start,
    input  logic                    in_end,
    output logic                    wr_en,
    input  logic                    wr_ack,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [OFF_WIDTH-1:0]    wr_off,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]   chk_addr,
    output logic                    chk_hit,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    wb_beat_t               in_beat, head;
    wb_beat_t [DEPTH-1:0]   entries;
    logic     [DEPTH-1:0]   ent_vld;
    logic                   full, empty, push, pop;
    trk_state_e             state_q, state_d;
    logic                   err_q, err_d, done_q;

    assign in_beat = '{data: in_data, be: in_be, addr: in_addr, off: in_off, last: in_end};

    wb_fifo #(.DEPTH(DEPTH), .entry_t(wb_beat_t)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .din_i     (in_beat),
        .dout_o    (head),
        .full_o    (full),
        .empty_o   (empty),
        .entries_o (entries),
        .vld_o     (ent_vld)
    );

    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign wr_en    = ~empty;
    assign pop      = wr_en & wr_ack;
    assign wr_addr  = head.addr;
    assign wr_off   = head.off;
    assign wr_data  = head.data;
    assign wr_be    = head.be;
    assign busy     = (state_q == TRK_OPEN) | ~empty;
    assign done     = done_q;
    assign err      = err_q;

    // Tracker, sticky error and done pulse registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TRK_IDLE;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            done_q  <= pop & head.last;
        end
    end

    // Framing checks on every accepted beat; a bad beat is flagged but still buffered.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (push) begin
            case (state_q)
                TRK_IDLE: begin
                    if (!in_start)          err_d   = 1'b1;
                    if (in_start && !in_end) state_d = TRK_OPEN;
                end
                TRK_OPEN: begin
                    if (in_start) err_d   = 1'b1;
                    if (in_end)   state_d = TRK_IDLE;
                end
                default: state_d = TRK_IDLE;
            endcase
        end
    end

    // Hazard hit on any live entry or on the beat entering this cycle.
    always_comb begin
        chk_hit = push && (in_addr == chk_addr);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (entries[i].addr == chk_addr)) chk_hit = 1'b1;
        end
    end

endmodule

// File: doc/vrf_wb_unit.md
VRF_WB_UNIT -- requirements
Module: vrf_wb_unit

Interface
REQ-001 SHALL have parameters: VLEN, default 16384, vector register length in bits; DATA_WIDTH, default 64, beat width; ADDR_WIDTH, default 5, register address width; OFF_WIDTH, default clog2(VLEN/DATA_WIDTH), word offset width; DEPTH, default 4, buffer entries (power of 2, at least 2).
REQ-002 SHALL have ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  result beat offered
- in_ready  out  1  beat can be accepted
- in_data  in  DATA_WIDTH  result data
- in_be  in  DATA_WIDTH/8  byte enables
- in_addr  in  ADDR_WIDTH  destination register
- in_off  in  OFF_WIDTH  word offset within register
- in_start  in  1  first beat of instruction
- in_end  in  1  last beat of instruction
- wr_en  out  1  VRF write request
- wr_ack  in  1  VRF accepts write this cycle
- wr_addr, wr_off, wr_data, wr_be  out  widths as in_*  VRF write fields
- chk_addr  in  ADDR_WIDTH  hazard query register
- chk_hit  out  1  pending write to chk_addr
- busy  out  1  instruction open or buffer non-empty
- done  out  1  one-cycle pulse, last beat written
- err  out  1  sticky protocol error

Function
REQ-003 SHALL accept a beat when in_valid and in_ready are both high at a rising edge (push).
REQ-004 SHALL hold up to DEPTH beats in a FIFO of entries {data, be, addr, off, end}.
REQ-005 SHALL drive in_ready = 1 exactly when occupancy < DEPTH; no push when full, even if a pop occurs in the same cycle.
REQ-006 SHALL drive wr_en = 1 exactly when occupancy > 0, with wr_* fields taken from the head entry.
REQ-007 SHALL pop the head when wr_en and wr_ack are both high; wr_* SHALL hold stable while wr_en=1 and wr_ack=0.
REQ-008 SHALL have no bypass: a beat pushed at edge N is visible on wr_* no earlier than the cycle after edge N.
REQ-009 SHALL update occupancy by +1 on push only, -1 on pop only, and hold it on simultaneous push and pop; read/write pointers SHALL wrap modulo DEPTH.
REQ-010 SHALL pulse done for exactly one cycle after any edge that pops an entry whose end bit is set.
REQ-011 SHALL keep an instruction tracker with states IDLE and OPEN. Transitions:
- IDLE -> OPEN on a push with in_start=1 and in_end=0
- OPEN -> IDLE on a push with in_end=1
- a push with in_start=1 and in_end=1 in IDLE leaves the state IDLE
REQ-012 SHALL set err on any of:
- a push with in_start=0 while IDLE
- a push with in_start=1 while OPEN
err SHALL hold until reset, and the offending beat SHALL still be buffered and written.
REQ-013 SHALL drive chk_hit = 1 combinationally when any valid FIFO entry, or the beat being pushed this cycle, has addr equal to chk_addr.
REQ-014 SHALL drive busy = (state == OPEN) or (occupancy > 0).
REQ-015 SHALL treat in_be as opaque: it is passed through unchanged, including all-zero values.

Reset
REQ-016 SHALL, while rst_n=0 at a rising edge, clear: occupancy, pointers, tracker (to IDLE), done, and err.
REQ-017 SHALL, after reset, present: in_ready=1, wr_en=0, chk_hit=0 (no entries), busy=0, done=0, err=0.
REQ-018 SHALL, on reset mid-operation, discard buffered beats without writing them and emit no done pulse.
REQ-019 SHALL NOT reset the data storage contents.

Structure
REQ-020 SHALL take VLEN, DATA_WIDTH, and ADDR_WIDTH defaults, and the beat-entry typedef {data, be, addr, off, end}, from the shared vector package.
REQ-021 SHALL instantiate one sub-module, wb_fifo: a parameterised synchronous FIFO exposing push, pop, full, empty, and the entry array for the hazard compare. Tracker, done, and err logic SHALL stay in vrf_wb_unit.

Verification
REQ-022 Single beat: push {addr=3, off=0, start=1, end=1} with wr_ack=1 -> wr_en=1 the next cycle with wr_addr=3; done pulses one cycle after the pop; busy returns to 0; err=0.
REQ-023 Full stream: push 256 beats (addr=8, off=0..255, start on the first, end on the last), wr_ack toggling 50% -> 256 writes in order with matching off; exactly one done pulse.
REQ-024 Backpressure: hold wr_ack=0 and push 4 beats -> in_ready=0 after the 4th push; wr_* stable; then one wr_ack -> in_ready=1 the next cycle; no beat lost or duplicated.
REQ-025 Hazard: with pending entries for addr 5 and 6, chk_addr=6 -> chk_hit=1, chk_addr=7 -> chk_hit=0; after both entries drain, chk_addr=6 -> chk_hit=0.
REQ-026 Protocol error: push with start=0 in IDLE -> err=1 (sticky) and the beat is still written; push start=1 while OPEN -> err stays 1.
REQ-027 Reset mid-stream: 3 beats buffered, rst_n=0 for one edge -> wr_en=0, in_ready=1, busy=0; no done pulse; no further writes.
